// File: rtl/weight_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// weight_mem_ctrl_pkg
//
// Purpose: shared definitions for the weight-memory sequencer of one layer.
//   - Default layer geometry (neurons, weights per neuron, widths).
//   - Sequencer state encoding.
//   - Helper that derives an index width from an element count.
//
// No ports (package).
// ---------------------------------------------------------------------------
package weight_mem_ctrl_pkg;

  // Width needed to index 'count' elements. Never returns less than 1, so a
  // single-element bank still gets a legal one-bit index.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int DEF_NUM_NEURONS   = 30;
  localparam int DEF_NUM_WEIGHT    = 784;
  localparam int DEF_ADDRESS_WIDTH = 10;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_NEURON_WIDTH  = index_width(DEF_NUM_NEURONS);

  // EMPTY : nothing loaded yet, waiting for the first config beat
  // LOAD  : streaming weights neuron by neuron into the memories
  // READY : every memory holds a full weight set, waiting for start
  // RUN   : scanning all memories in lockstep with the layer inputs
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/weight_mem_ctrl_addr_counter.sv
// ---------------------------------------------------------------------------
// weight_addr_counter
//
// Purpose: address counter shared by the write pointer (load path) and the
// read pointer (inference scan). Counts up by one when enabled, stops at
// lastValue instead of wrapping, and raises at_last while sitting there.
// A clear has priority over an increment.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, count returns to 0
//   en       in   advance the count (ignored once at lastValue)
//   clr      in   return the count to 0 on the next edge
//   count    out  current address
//   at_last  out  count == lastValue
// ---------------------------------------------------------------------------
module weight_addr_counter
  import weight_mem_ctrl_pkg::*;
#(
  parameter int addressWidth = DEF_ADDRESS_WIDTH,
  parameter int lastValue    = DEF_NUM_WEIGHT - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  output logic [addressWidth-1:0] count,
  output logic                    at_last
);

  assign at_last = (count == addressWidth'(lastValue));

  // Saturating counter: an over-long weight stream keeps rewriting the final
  // address rather than wrapping onto the start of the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_last) begin
      count <= count + addressWidth'(1);
    end
  end

endmodule

// File: rtl/weight_mem_ctrl.sv
// ---------------------------------------------------------------------------
// weight_mem_ctrl
//
// Purpose: sequencer for a layer's bank of per-neuron weight memories
// (1-cycle read latency, one write port each). Loads weights neuron by
// neuron from a valid/ready config stream, then scans every memory in
// lockstep with the layer's input stream during inference.
//
// Build option:
//   PRETRAINED_WEIGHTS_EN  memories come up pre-initialised; the load path is
//                          not built, reset lands directly in READY with
//                          load_done=1, cfg_ready and wen are tied low.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (returns to EMPTY)
//   cfg_valid   in   config weight beat valid
//   cfg_ready   out  beat accepted when cfg_valid & cfg_ready
//   cfg_data    in   weight value
//   cfg_last    in   final weight of the current neuron
//   start       in   one-cycle pulse, begins one inference scan
//   in_valid    in   one layer input presented this cycle
//   wen         out  one-hot write enables, one per neuron memory
//   wadd        out  shared write address
//   win         out  shared write data
//   ren         out  read enable to all memories
//   radd        out  shared read address
//   wout_valid  out  memory read data valid (ren delayed one cycle)
//   load_done   out  level, every neuron has been loaded
//   run_done    out  one-cycle pulse, scan complete
//   cfg_err     out  sticky, a neuron's weight stream was the wrong length
// ---------------------------------------------------------------------------
module weight_mem_ctrl
  import weight_mem_ctrl_pkg::*;
#(
  parameter int numNeurons   = DEF_NUM_NEURONS,
  parameter int numWeight    = DEF_NUM_WEIGHT,
  parameter int addressWidth = DEF_ADDRESS_WIDTH,
  parameter int dataWidth    = DEF_DATA_WIDTH,
  parameter int neuronWidth  = DEF_NEURON_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [dataWidth-1:0]    cfg_data,
  input  logic                    cfg_last,
  input  logic                    start,
  input  logic                    in_valid,
  output logic [numNeurons-1:0]   wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  output logic                    wout_valid,
  output logic                    load_done,
  output logic                    run_done,
  output logic                    cfg_err
);

  state_t                  state;
  logic [addressWidth-1:0] rd_count;
  logic                    rd_last;
  logic                    rd_clr;

  // Reads only happen inside a scan. Gating with rst keeps a read from
  // escaping on the cycle the sequencer is being thrown back to EMPTY.
  assign ren    = !rst && (state == ST_RUN) && in_valid;
  assign radd   = rd_count;
  assign rd_clr = ren && rd_last;

  weight_addr_counter #(
    .addressWidth (addressWidth),
    .lastValue    (numWeight - 1)
  ) u_read_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (ren),
    .clr     (rd_clr),
    .count   (rd_count),
    .at_last (rd_last)
  );

`ifndef PRETRAINED_WEIGHTS_EN
  logic                    load_ready;
  logic [addressWidth-1:0] wptr;
  logic                    wptr_last;
  logic [neuronWidth-1:0]  nidx;
  logic                    accept;
  logic                    beat_err;
  logic                    last_neuron;

  assign cfg_ready   = load_ready;
  assign accept      = cfg_valid && load_ready && !rst;

  // A neuron's stream is well formed only when cfg_last lands exactly on the
  // final weight address; either mismatch direction is a malformed load.
  assign beat_err    = (cfg_last != wptr_last);
  assign last_neuron = (nidx == neuronWidth'(numNeurons - 1));

  weight_addr_counter #(
    .addressWidth (addressWidth),
    .lastValue    (numWeight - 1)
  ) u_write_counter (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .clr     (accept && cfg_last),
    .count   (wptr),
    .at_last (wptr_last)
  );

  // Writes go out in the same cycle as the accepted beat so the memory sees
  // data, address and strobe together without an extra pipeline stage.
  assign wen  = accept ? (numNeurons'(1) << nidx) : '0;
  assign wadd = wptr;
  assign win  = accept ? cfg_data : '0;
`else
  logic unused_cfg;

  assign unused_cfg = ^{cfg_valid, cfg_data, cfg_last};
  assign cfg_ready  = 1'b0;
  assign wen        = '0;
  assign wadd       = '0;
  assign win        = '0;
`endif

  // Main sequencer. load_done, run_done, cfg_err, wout_valid and the load
  // handshake ready are all registered here so downstream logic sees clean
  // flop outputs. A reload after READY is only possible through rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_done   <= 1'b0;
      wout_valid <= 1'b0;
      cfg_err    <= 1'b0;
`ifdef PRETRAINED_WEIGHTS_EN
      state      <= ST_READY;
      load_done  <= 1'b1;
`else
      state      <= ST_EMPTY;
      load_done  <= 1'b0;
      load_ready <= 1'b0;
      nidx       <= '0;
`endif
    end else begin
      run_done   <= 1'b0;
      wout_valid <= ren;
      case (state)
`ifndef PRETRAINED_WEIGHTS_EN
        ST_EMPTY, ST_LOAD: begin
          load_ready <= 1'b1;
          if (accept) begin
            state <= ST_LOAD;
            if (beat_err) begin
              cfg_err <= 1'b1;
            end
            if (cfg_last) begin
              if (last_neuron) begin
                state      <= ST_READY;
                load_done  <= 1'b1;
                load_ready <= 1'b0;
              end else begin
                nidx <= nidx + neuronWidth'(1);
              end
            end
          end
        end
`endif
        ST_READY: begin
          // in_valid alongside start is deliberately ignored; the scan's
          // first read happens on the following cycle.
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ren && rd_last) begin
            state    <= ST_READY;
            run_done <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/weight_mem_ctrl.md
Name: weight_mem_ctrl

Overview:
Sequencer for a layer's bank of per-neuron weight memories (1-cycle-read, single write port each). Loads weights neuron-by-neuron from a valid/ready config stream, driving one-hot write enables with auto-incrementing addresses. Scans all memories in lockstep with the layer's input stream during inference, with a per-beat read-data-valid strobe. Sits between the layer's config/AXI glue and the weight memories feeding each neuron's MAC.

Parameters:
numNeurons, 30, weight memories (neurons) in the layer
numWeight, 784, weights per neuron (= layer inputs)
addressWidth, 10, memory address width; numWeight <= 2**addressWidth
dataWidth, 16, weight word width
neuronWidth, 5, neuron index width; numNeurons <= 2**neuronWidth

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
cfg_valid  in  1  config weight beat valid
cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready
cfg_data  in  dataWidth  weight value
cfg_last  in  1  marks final weight of current neuron
start  in  1  begin one inference scan (single-cycle pulse)
in_valid  in  1  one layer input presented this cycle
wen  out  numNeurons  one-hot memory write enables
wadd  out  addressWidth  write address (shared)
win  out  dataWidth  write data (shared)
ren  out  1  read enable to all memories
radd  out  addressWidth  read address (shared)
wout_valid  out  1  memory outputs valid (ren delayed 1 cycle)
load_done  out  1  level: all neurons loaded
run_done  out  1  1-cycle pulse: scan complete
cfg_err  out  1  sticky: malformed load

Behaviour:
- Reset values: all outputs 0; wadd/radd/win 0; state EMPTY; neuron index 0; cfg_err 0.
- States: EMPTY, LOAD, READY, RUN.
- EMPTY: cfg_ready=1; first accepted beat enters LOAD, handled like a LOAD beat. start ignored.
- LOAD: cfg_ready=1. Per accepted beat, same cycle:
  - wen[nidx]=1, wadd=wptr, win=cfg_data; wptr++.
  - On cfg_last: wptr->0, nidx++.
  - Last beat of neuron numNeurons-1 -> READY; load_done=1 from next cycle.
- Load errors:
  - cfg_last with wptr != numWeight-1, or beat at wptr == numWeight-1 without cfg_last: set cfg_err.
  - Extra beat at wptr == numWeight-1: write performed; wptr saturates, never wraps; neuron still advances on cfg_last.
- READY: cfg_ready=0; start -> RUN, radd=0.
- RUN:
  - ren = in_valid, combinational; radd = current count.
  - Each in_valid: count++.
  - in_valid at count == numWeight-1: run_done next cycle, then READY; radd->0.
  - start/cfg ignored; cfg_ready=0.
- wout_valid = ren registered 1 cycle; tracks memory read latency exactly.
- start and in_valid same cycle in READY: in_valid ignored (scan begins next cycle).
- Back-to-back scans: start may arrive the cycle after run_done.
- rst mid-LOAD or mid-RUN: immediate EMPTY; memory contents unchanged but load_done=0, so a full reload is required.
- Reload after READY only via rst.

Optional Feature:
PRETRAINED_WEIGHTS_EN
- Defined: memories are initialized from files. Reset state is READY with load_done=1; cfg_ready tied 0; wen tied 0; LOAD/EMPTY logic is not built.
- Undefined: full load path as above.

Decomposition:
- Shared package: state encoding (EMPTY/LOAD/READY/RUN), default numNeurons/numWeight/addressWidth/dataWidth, neuronWidth derivation.
- One sub-module is natural: weight_addr_counter (enable, clear, saturating terminal-count flag), instantiated for wptr and the read count.

Test Plan:
- Load numNeurons=2, numWeight=3, 6 beats (last on 3rd/6th), cfg_valid held -> wen = 01,01,01,10,10,10; wadd 0,1,2,0,1,2; load_done=1 cycle after 6th beat; cfg_err=0.
- Load with cfg_valid toggling every other cycle -> writes only on handshake cycles; same address/one-hot sequence.
- start, then in_valid on 3 non-consecutive cycles -> ren on those cycles with radd 0,1,2; wout_valid 1 cycle after each ren; run_done pulse after 3rd; state READY; cfg_ready=0.
- cfg_last on 2nd beat of neuron 0 (numWeight=3) -> cfg_err=1 sticky; next beat writes wen=10, wadd=0.
- rst asserted during RUN after radd=1 -> next cycle: all outputs 0, load_done=0; start ignored until reload.
- With PRETRAINED_WEIGHTS_EN: after rst, load_done=1, cfg_ready=0; start plus 3 in_valid -> radd 0,1,2, run_done pulse.
